// File: rtl/chimera_pkg.sv
// Shared types and default timing constants for the Chimera cluster power sequencer.
package chimera_pkg;

    typedef enum logic [2:0] {
        FSM_OFF        = 3'd0,
        FSM_WAKE_CLK   = 3'd1,
        FSM_WAKE_RST   = 3'd2,
        FSM_WAKE_DEISO = 3'd3,
        FSM_ON         = 3'd4,
        FSM_SLP_ISO    = 3'd5,
        FSM_SLP_RST    = 3'd6,
        FSM_SLP_CLK    = 3'd7
    } cluster_pwr_fsm_e;

    typedef enum logic [1:0] {
        PWR_OFF  = 2'b00,
        PWR_UP   = 2'b01,
        PWR_ON   = 2'b10,
        PWR_DOWN = 2'b11
    } cluster_pwr_state_e;

    localparam int unsigned ClusterClkSettleCycles = 32'd4;
    localparam int unsigned ClusterRstCycles       = 32'd8;
    localparam int unsigned ClusterIsoTimeout      = 32'd1024;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/chimera_cluster_pwr_fsm.sv
// Single-channel power sequencer: isolation, clock gate and reset stepped in a fixed
// order, with a per-state cycle counter and a sticky isolation-timeout flag.
module chimera_cluster_pwr_fsm
    import chimera_pkg::*;
#(
    parameter int unsigned ClkSettleCycles = ClusterClkSettleCycles,
    parameter int unsigned RstCycles       = ClusterRstCycles,
    parameter int unsigned IsoTimeout      = ClusterIsoTimeout,
    parameter int unsigned CntWidth        = 11
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pwr_req_i,
    input  logic       err_clr_i,
    input  logic       isolated_i,
    output logic       isolate_o,
    output logic       clk_en_o,
    output logic       rst_no,
    output logic [1:0] pwr_state_o,
    output logic       err_o,
    output logic       busy_nxt_o
);

    localparam logic [CntWidth-1:0] SettleLast = CntWidth'(ClkSettleCycles - 32'd1);
    localparam logic [CntWidth-1:0] RstLast    = CntWidth'(RstCycles - 32'd1);
    localparam logic [CntWidth-1:0] IsoLast    = CntWidth'(IsoTimeout - 32'd1);
    localparam logic [CntWidth-1:0] CntMax     = {CntWidth{1'b1}};

    cluster_pwr_fsm_e   state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic               err_q, err_d, err_set_s;
    logic               iso_q, iso_d, clk_en_q, clk_en_d, rst_n_q, rst_n_d;
    cluster_pwr_state_e pst_q, pst_d;

    // Next-state logic; timeouts force progress so the cluster never stalls half-isolated.
    always_comb begin
        state_d   = state_q;
        err_set_s = 1'b0;
        case (state_q)
            FSM_OFF: begin
                if (pwr_req_i) state_d = FSM_WAKE_CLK;
                else           state_d = FSM_OFF;
            end
            FSM_WAKE_CLK: begin
                if (cnt_q == SettleLast) state_d = FSM_WAKE_RST;
                else                     state_d = FSM_WAKE_CLK;
            end
            FSM_WAKE_RST: begin
                if (cnt_q == RstLast) state_d = FSM_WAKE_DEISO;
                else                  state_d = FSM_WAKE_RST;
            end
            FSM_WAKE_DEISO: begin
                if (!isolated_i) begin
                    state_d = FSM_ON;
                end else if (cnt_q == IsoLast) begin
                    state_d   = FSM_ON;
                    err_set_s = 1'b1;
                end else begin
                    state_d = FSM_WAKE_DEISO;
                end
            end
            FSM_ON: begin
                if (!pwr_req_i) state_d = FSM_SLP_ISO;
                else            state_d = FSM_ON;
            end
            FSM_SLP_ISO: begin
                // Abort back to de-isolation rather than reset an unisolated cluster.
                if (isolated_i) begin
                    state_d = FSM_SLP_RST;
                end else if (cnt_q == IsoLast) begin
                    state_d   = FSM_WAKE_DEISO;
                    err_set_s = 1'b1;
                end else begin
                    state_d = FSM_SLP_ISO;
                end
            end
            FSM_SLP_RST: begin
                if (cnt_q == RstLast) state_d = FSM_SLP_CLK;
                else                  state_d = FSM_SLP_RST;
            end
            FSM_SLP_CLK: state_d = FSM_OFF;
            default:     state_d = FSM_OFF;
        endcase
    end

    // Counter restarts on every state change and saturates while idle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = {CntWidth{1'b0}};
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntWidth'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Sticky error flag: a new timeout wins over a coincident clear.
    always_comb begin
        err_d = err_q;
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Output decode from the next state so the output flops track state_q exactly.
    always_comb begin
        iso_d      = 1'b1;
        clk_en_d   = 1'b0;
        rst_n_d    = 1'b0;
        pst_d      = PWR_OFF;
        busy_nxt_o = 1'b1;
        case (state_d)
            FSM_OFF:        begin iso_d = 1'b1; clk_en_d = 1'b0; rst_n_d = 1'b0; pst_d = PWR_OFF;  busy_nxt_o = 1'b0; end
            FSM_WAKE_CLK:   begin iso_d = 1'b1; clk_en_d = 1'b1; rst_n_d = 1'b0; pst_d = PWR_UP;   end
            FSM_WAKE_RST:   begin iso_d = 1'b1; clk_en_d = 1'b1; rst_n_d = 1'b1; pst_d = PWR_UP;   end
            FSM_WAKE_DEISO: begin iso_d = 1'b0; clk_en_d = 1'b1; rst_n_d = 1'b1; pst_d = PWR_UP;   end
            FSM_ON:         begin iso_d = 1'b0; clk_en_d = 1'b1; rst_n_d = 1'b1; pst_d = PWR_ON;   busy_nxt_o = 1'b0; end
            FSM_SLP_ISO:    begin iso_d = 1'b1; clk_en_d = 1'b1; rst_n_d = 1'b1; pst_d = PWR_DOWN; end
            FSM_SLP_RST:    begin iso_d = 1'b1; clk_en_d = 1'b1; rst_n_d = 1'b0; pst_d = PWR_DOWN; end
            FSM_SLP_CLK:    begin iso_d = 1'b1; clk_en_d = 1'b0; rst_n_d = 1'b0; pst_d = PWR_DOWN; end
            default:        begin iso_d = 1'b1; clk_en_d = 1'b0; rst_n_d = 1'b0; pst_d = PWR_OFF;  busy_nxt_o = 1'b0; end
        endcase
    end

    // State, counter, error and output registers; reset drops straight to the safe OFF values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= FSM_OFF;
            cnt_q    <= {CntWidth{1'b0}};
            err_q    <= 1'b0;
            iso_q    <= 1'b1;
            clk_en_q <= 1'b0;
            rst_n_q  <= 1'b0;
            pst_q    <= PWR_OFF;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            iso_q    <= iso_d;
            clk_en_q <= clk_en_d;
            rst_n_q  <= rst_n_d;
            pst_q    <= pst_d;
        end
    end

    assign isolate_o   = iso_q;
    assign clk_en_o    = clk_en_q;
    assign rst_no      = rst_n_q;
    assign pwr_state_o = pst_q;
    assign err_o       = err_q;

endmodule

// File: rtl/chimera_cluster_pwr_seq.sv
// N-channel cluster power sequencer: one independent FSM per cluster plus a registered
// aggregate busy flag.
module chimera_cluster_pwr_seq
    import chimera_pkg::*;
#(
    parameter int unsigned NumClusters     = 5,
    parameter int unsigned ClkSettleCycles = ClusterClkSettleCycles,
    parameter int unsigned RstCycles       = ClusterRstCycles,
    parameter int unsigned IsoTimeout      = ClusterIsoTimeout
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumClusters-1:0]   pwr_req_i,
    input  logic [NumClusters-1:0]   err_clr_i,
    input  logic [NumClusters-1:0]   isolated_i,
    output logic [NumClusters-1:0]   isolate_o,
    output logic [NumClusters-1:0]   clk_en_o,
    output logic [NumClusters-1:0]   rst_no,
    output logic [2*NumClusters-1:0] pwr_state_o,
    output logic [NumClusters-1:0]   err_o,
    output logic                     busy_o
);

    localparam int unsigned CntWidth = $clog2(max3(ClkSettleCycles, RstCycles, IsoTimeout) + 32'd1);

    logic [NumClusters-1:0] busy_nxt_s;
    logic                   busy_q;

    for (genvar g = 0; g < NumClusters; g++) begin : g_cluster
        chimera_cluster_pwr_fsm #(
            .ClkSettleCycles (ClkSettleCycles),
            .RstCycles       (RstCycles),
            .IsoTimeout      (IsoTimeout),
            .CntWidth        (CntWidth)
        ) u_fsm (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .pwr_req_i   (pwr_req_i[g]),
            .err_clr_i   (err_clr_i[g]),
            .isolated_i  (isolated_i[g]),
            .isolate_o   (isolate_o[g]),
            .clk_en_o    (clk_en_o[g]),
            .rst_no      (rst_no[g]),
            .pwr_state_o (pwr_state_o[2*g +: 2]),
            .err_o       (err_o[g]),
            .busy_nxt_o  (busy_nxt_s[g])
        );
    end

    // Aggregate busy is registered from the per-channel next states to stay cycle-aligned.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |busy_nxt_s;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: tb/tb_chimera_cluster_pwr_seq.sv
// Self-checking bench: directed latency/timeout scenarios plus randomized traffic, all
// compared against a table-driven behavioural model of the sequencer.
module tb_chimera_cluster_pwr_seq;

    localparam int NC  = 5;
    localparam int SET = 4;
    localparam int RST = 8;
    localparam int TO  = 1024;

    // Phase order: off, up-clk, up-rst, up-deiso, on, dn-iso, dn-rst, dn-clk
    localparam logic [2:0] OUT_TAB [8] = '{3'b100, 3'b110, 3'b111, 3'b011,
                                           3'b011, 3'b111, 3'b110, 3'b100};
    localparam logic [1:0] ST_TAB  [8] = '{2'b00, 2'b01, 2'b01, 2'b01,
                                           2'b10, 2'b11, 2'b11, 2'b11};

    typedef struct {
        int   ph;
        int   age;
        logic err;
    } ms_t;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NC-1:0]     pwr_req_i = '0;
    logic [NC-1:0]     err_clr_i = '0;
    logic [NC-1:0]     isolated_i;
    logic [NC-1:0]     isolate_o, clk_en_o, rst_no, err_o;
    logic [2*NC-1:0]   pwr_state_o;
    logic              busy_o;

    int                n_cmp = 0;
    int                n_err = 0;
    int                dly [NC];
    logic [NC-1:0]     stuck_en = '0;
    logic [NC-1:0]     stuck_val = '0;
    logic [3:0]        hist [NC];
    ms_t               m [NC];

    logic [NC-1:0]     exp_iso, exp_clk, exp_rst, exp_err;
    logic [2*NC-1:0]   exp_st;
    logic              exp_busy;
    logic [30:0]       act_vec, exp_vec;

    chimera_cluster_pwr_seq #(.NumClusters(NC)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .pwr_req_i   (pwr_req_i),
        .err_clr_i   (err_clr_i),
        .isolated_i  (isolated_i),
        .isolate_o   (isolate_o),
        .clk_en_o    (clk_en_o),
        .rst_no      (rst_no),
        .pwr_state_o (pwr_state_o),
        .err_o       (err_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Isolate-cell response: stuck, immediate, or delayed by dly[c] cycles.
    always @(posedge clk_i or negedge rst_ni) begin
        for (int c = 0; c < NC; c++) begin
            if (!rst_ni) hist[c] <= 4'hF;
            else         hist[c] <= {hist[c][2:0], isolate_o[c]};
        end
    end

    always_comb begin
        isolated_i = '0;
        for (int c = 0; c < NC; c++) begin
            if (stuck_en[c])    isolated_i[c] = stuck_val[c];
            else if (dly[c] == 0) isolated_i[c] = isolate_o[c];
            else                isolated_i[c] = hist[c][dly[c]-1];
        end
    end

    function automatic ms_t mnext(input ms_t s, input logic req, input logic clr, input logic iso);
        ms_t  n;
        int   np;
        logic set;
        np  = s.ph;
        set = 1'b0;
        case (s.ph)
            0: if (req) np = 1;
            1: if (s.age >= SET - 1) np = 2;
            2: if (s.age >= RST - 1) np = 3;
            3: if (!iso) np = 4; else if (s.age >= TO - 1) begin np = 4; set = 1'b1; end
            4: if (!req) np = 5;
            5: if (iso) np = 6; else if (s.age >= TO - 1) begin np = 3; set = 1'b1; end
            6: if (s.age >= RST - 1) np = 7;
            default: np = 0;
        endcase
        n.ph  = np;
        n.age = (np != s.ph) ? 0 : s.age + 1;
        n.err = set ? 1'b1 : (clr ? 1'b0 : s.err);
        return n;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        for (int c = 0; c < NC; c++) begin
            if (!rst_ni) m[c] <= '{ph: 0, age: 0, err: 1'b0};
            else         m[c] <= mnext(m[c], pwr_req_i[c], err_clr_i[c], isolated_i[c]);
        end
    end

    always_comb begin
        exp_iso = '0; exp_clk = '0; exp_rst = '0; exp_err = '0; exp_st = '0; exp_busy = 1'b0;
        for (int c = 0; c < NC; c++) begin
            exp_iso[c] = OUT_TAB[m[c].ph][2];
            exp_clk[c] = OUT_TAB[m[c].ph][1];
            exp_rst[c] = OUT_TAB[m[c].ph][0];
            exp_st[2*c +: 2] = ST_TAB[m[c].ph];
            exp_err[c] = m[c].err;
            if (m[c].ph != 0 && m[c].ph != 4) exp_busy = 1'b1;
        end
    end

    assign act_vec = {isolate_o, clk_en_o, rst_no, pwr_state_o, err_o, busy_o};
    assign exp_vec = {exp_iso, exp_clk, exp_rst, exp_st, exp_err, exp_busy};

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if ({isolate_o, clk_en_o, rst_no, pwr_state_o, err_o, busy_o} !== {5'h1F, 5'h00, 5'h00, 10'h000, 5'h00, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values act=%h req=%h", act_vec, {5'h1F, 26'h0});
        end
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        n_cmp++;
        if (act_vec !== exp_vec) begin
            n_err++;
            $display("FAIL reset_idle act=%h req=%h", act_vec, exp_vec);
        end
    endtask

    task automatic test_power_up();
        int t_clk = -1, t_rst = -1, t_iso = -1, t_on = -1;
        pwr_req_i[2] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_i);
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_err++;
                $display("FAIL up_model k=%0d act=%h req=%h", k, act_vec, exp_vec);
            end
            n_cmp++;
            if (busy_o !== (k <= 13)) begin
                n_err++;
                $display("FAIL up_busy k=%0d act=%b req=%b", k, busy_o, (k <= 13));
            end
            if (t_clk < 0 && clk_en_o[2]) t_clk = k;
            if (t_rst < 0 && rst_no[2]) t_rst = k;
            if (t_iso < 0 && !isolate_o[2]) t_iso = k;
            if (t_on < 0 && pwr_state_o[5:4] == 2'b10) t_on = k;
        end
        n_cmp++;
        if ({t_clk, t_rst, t_iso, t_on} !== {32'd1, 32'd5, 32'd13, 32'd14}) begin
            n_err++;
            $display("FAIL up_latency act=%0d/%0d/%0d/%0d req=1/5/13/14", t_clk, t_rst, t_iso, t_on);
        end
    endtask

    task automatic test_power_down();
        int t_rst = -1, t_clk = -1, t_off = -1;
        dly[2] = 2;  // isolated_i rises 3 cycles after the request drops
        pwr_req_i[2] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_i);
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_err++;
                $display("FAIL down_model k=%0d act=%h req=%h", k, act_vec, exp_vec);
            end
            if (t_rst < 0 && !rst_no[2]) t_rst = k;
            if (t_clk < 0 && !clk_en_o[2]) t_clk = k;
            if (t_off < 0 && pwr_state_o[5:4] == 2'b00) t_off = k;
        end
        n_cmp++;
        if ({t_rst, t_clk, t_off} !== {32'd4, 32'd12, 32'd13}) begin
            n_err++;
            $display("FAIL down_latency act=%0d/%0d/%0d req=4/12/13", t_rst, t_clk, t_off);
        end
        dly[2] = 0;
    endtask

    task automatic test_timeout();
        int t_err = -1, rst_drop = 0;
        pwr_req_i[0] = 1'b1;
        repeat (16) @(negedge clk_i);
        stuck_en[0]  = 1'b1;
        stuck_val[0] = 1'b0;
        pwr_req_i[0] = 1'b0;
        for (int k = 1; k <= 2056; k++) begin
            @(negedge clk_i);
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_err++;
                $display("FAIL to_model k=%0d act=%h req=%h", k, act_vec, exp_vec);
            end
            if (rst_no[0] !== 1'b1) rst_drop++;
            if (t_err < 0 && err_o[0]) t_err = k;
            if (k == 1026) begin
                n_cmp++;
                if (pwr_state_o[1:0] !== 2'b10) begin
                    n_err++;
                    $display("FAIL to_back_on act=%b req=10", pwr_state_o[1:0]);
                end
            end
            if (k == 1031 || k == 2051) begin
                n_cmp++;
                if (err_o[0] !== (k == 2051)) begin
                    n_err++;
                    $display("FAIL to_err_clr k=%0d act=%b req=%b", k, err_o[0], (k == 2051));
                end
            end
            err_clr_i[0] = (k == 1030 || k == 2050);
        end
        n_cmp++;
        if (t_err !== 1025 || rst_drop !== 0) begin
            n_err++;
            $display("FAIL to_err_time act=%0d drops=%0d req=1025 drops=0", t_err, rst_drop);
        end
        err_clr_i[0] = 1'b0;
        stuck_en[0]  = 1'b0;
    endtask

    task automatic test_toggle();
        int t_on = -1, t_off = -1;
        repeat (20) @(negedge clk_i);
        pwr_req_i[1] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk_i);
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_err++;
                $display("FAIL tog_model k=%0d act=%h req=%h", k, act_vec, exp_vec);
            end
            if (t_on < 0 && pwr_state_o[3:2] == 2'b10) t_on = k;
            if (t_on > 0 && t_off < 0 && pwr_state_o[3:2] == 2'b00) t_off = k;
            if (k == 1) pwr_req_i[1] = 1'b0;
        end
        n_cmp++;
        if (t_on !== 14 || t_off !== 25) begin
            n_err++;
            $display("FAIL tog_seq act=%0d/%0d req=14/25", t_on, t_off);
        end
    endtask

    task automatic test_all_parallel();
        for (int c = 0; c < NC; c++) dly[c] = 0;
        repeat (20) @(negedge clk_i);
        pwr_req_i = 5'h1F;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk_i);
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_err++;
                $display("FAIL par_model k=%0d act=%h req=%h", k, act_vec, exp_vec);
            end
            if (k == 13 || k == 14) begin
                n_cmp++;
                if (pwr_state_o !== ((k == 13) ? 10'h155 : 10'h2AA)) begin
                    n_err++;
                    $display("FAIL par_state k=%0d act=%h req=%h", k, pwr_state_o,
                             (k == 13) ? 10'h155 : 10'h2AA);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        pwr_req_i = '0;
        repeat (16) @(negedge clk_i);
        pwr_req_i[3] = 1'b1;
        repeat (7) @(negedge clk_i);
        n_cmp++;
        if (pwr_state_o[7:6] !== 2'b01 || rst_no[3] !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_pre act=%b/%b req=01/1", pwr_state_o[7:6], rst_no[3]);
        end
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({isolate_o, clk_en_o, rst_no, pwr_state_o, err_o, busy_o} !== {5'h1F, 26'h0}) begin
            n_err++;
            $display("FAIL rmid_async act=%h req=%h", act_vec, {5'h1F, 26'h0});
        end
        n_cmp++;
        if (act_vec !== exp_vec) begin
            n_err++;
            $display("FAIL rmid_model act=%h req=%h", act_vec, exp_vec);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            @(negedge clk_i);
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_err++;
                $display("FAIL rand_model k=%0d act=%h req=%h", k, act_vec, exp_vec);
            end
            if (k % 200 == 0) begin
                for (int c = 0; c < NC; c++) dly[c] = int'($urandom_range(0, 3));
            end
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 15) == 0) pwr_req_i[c] = ~pwr_req_i[c];
                err_clr_i[c] = ($urandom_range(0, 15) == 0);
            end
        end
        err_clr_i = '0;
    endtask

    initial begin
        for (int c = 0; c < NC; c++) dly[c] = 0;
        @(negedge clk_i);
        test_reset();
        test_power_up();
        test_power_down();
        test_timeout();
        test_toggle();
        test_all_parallel();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
